// File: rtl/run_sequencer.sv
`timescale 1ns/1ps
// Host run controller: loads a byte stream into core data memory, resets and starts the core, waits for done/timeout.
// Latency: load handshake -> mem write next cycle; last byte -> 2 core-reset cycles -> core_req on the 3rd cycle.
// Backpressure: ld_ready is high only in LOAD, and bytes offered in any other state are dropped.
// Ports: clk/reset (async active-low); host load stream ld_*; data-memory write port mem_*;
//        core control core_reset/core_req/core_done; status busy/done/timeout/cycle_count/load_csum.
// Build option: define RUN_SEQ_CHECKSUM_EN to build the XOR load checksum (otherwise load_csum reads 0).
module run_sequencer #(
    parameter int              AW         = 8,
    parameter int              CW         = 16,
    parameter logic [CW-1:0]   MAX_CYCLES = CW'(16'hFFFF)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic [AW-1:0] ld_addr,
    input  logic [7:0]    ld_data,
    input  logic          ld_last,
    output logic          mem_wr_en,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_dat,
    output logic          core_reset,
    output logic          core_req,
    input  logic          core_done,
    output logic          busy,
    output logic          done,
    output logic          timeout,
    output logic [CW-1:0] cycle_count,
    output logic [7:0]    load_csum
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        CORE_RST = 3'd2,
        RUN      = 3'd3,
        DONE     = 3'd4,
        TOUT     = 3'd5
    } state_t;

    state_t        state;
    logic          crst_cnt;     // second CORE_RST cycle marker
    logic          load_hs;
    logic          restart;
    logic [CW-1:0] count_inc;

    assign ld_ready = (state == LOAD);
    assign busy     = (state == LOAD) || (state == CORE_RST) || (state == RUN);
    assign load_hs  = ld_valid && ld_ready;
    // A new run may only be launched from a resting state.
    assign restart  = start && ((state == IDLE) || (state == DONE) || (state == TOUT));

    // Saturating increment; the count never wraps back to zero.
    assign count_inc = (&cycle_count) ? cycle_count : cycle_count + CW'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            crst_cnt    <= 1'b0;
            mem_wr_en   <= 1'b0;
            mem_addr    <= '0;
            mem_dat     <= '0;
            core_reset  <= 1'b1;
            core_req    <= 1'b0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            cycle_count <= '0;
        end else begin
            // Single-cycle strobes default low.
            mem_wr_en <= 1'b0;
            core_req  <= 1'b0;

            case (state)
                IDLE, DONE, TOUT: begin
                    if (restart) begin
                        state       <= LOAD;
                        done        <= 1'b0;
                        timeout     <= 1'b0;
                        cycle_count <= '0;
                        core_reset  <= 1'b1;
                    end
                end

                LOAD: begin
                    if (load_hs) begin
                        mem_wr_en <= 1'b1;
                        mem_addr  <= ld_addr;
                        mem_dat   <= ld_data;
                        if (ld_last) begin
                            state    <= CORE_RST;
                            crst_cnt <= 1'b0;
                        end
                    end
                end

                CORE_RST: begin
                    if (crst_cnt) begin
                        // Entering RUN: release core, pulse req, and count this first RUN cycle.
                        state       <= RUN;
                        core_reset  <= 1'b0;
                        core_req    <= 1'b1;
                        cycle_count <= count_inc;
                    end else begin
                        crst_cnt <= 1'b1;
                    end
                end

                RUN: begin
                    // cycle_count already includes the current cycle, so done wins a tie with the limit.
                    if (core_done) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else if (cycle_count >= MAX_CYCLES) begin
                        state      <= TOUT;
                        timeout    <= 1'b1;
                        core_reset <= 1'b1;
                    end else begin
                        cycle_count <= count_inc;
                    end
                end

                default: begin
                    state      <= IDLE;
                    core_reset <= 1'b1;
                end
            endcase
        end
    end

`ifdef RUN_SEQ_CHECKSUM_EN
    logic [7:0] csum;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            csum <= 8'h00;
        end else if (restart) begin
            csum <= 8'h00;
        end else if (load_hs) begin
            csum <= csum ^ ld_data;
        end
    end

    assign load_csum = csum;
`else
    assign load_csum = 8'h00;
`endif

endmodule

// File: tb/tb_run_sequencer.sv
`timescale 1ns/1ps
// Self-checking bench for run_sequencer: directed load/run scenarios with scoreboarded memory writes and completion status.
// Latency: checks the exact cycle positions of core_reset/core_req/cycle_count around the load and run phases.
// Backpressure: exercises ld_valid while ld_ready is low (ignored) and start pulses in busy states.
module tb_run_sequencer;

    localparam int AW = 8;
    localparam int CW = 16;

`ifdef RUN_SEQ_CHECKSUM_EN
    localparam logic [7:0] CS_MASK = 8'hFF;
`else
    localparam logic [7:0] CS_MASK = 8'h00;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          ld_valid = 1'b0;
    logic          ld_ready;
    logic [AW-1:0] ld_addr = '0;
    logic [7:0]    ld_data = '0;
    logic          ld_last = 1'b0;
    logic          mem_wr_en;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_dat;
    logic          core_reset;
    logic          core_req;
    logic          core_done = 1'b0;
    logic          busy;
    logic          done;
    logic          timeout;
    logic [CW-1:0] cycle_count;
    logic [7:0]    load_csum;

    run_sequencer #(
        .AW         (AW),
        .CW         (CW),
        .MAX_CYCLES (16'd20)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .ld_last     (ld_last),
        .mem_wr_en   (mem_wr_en),
        .mem_addr    (mem_addr),
        .mem_dat     (mem_dat),
        .core_reset  (core_reset),
        .core_req    (core_req),
        .core_done   (core_done),
        .busy        (busy),
        .done        (done),
        .timeout     (timeout),
        .cycle_count (cycle_count),
        .load_csum   (load_csum)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    dat;
    } wr_t;

    typedef struct packed {
        logic          done;
        logic          timeout;
        logic [CW-1:0] cnt;
        logic          core_reset;
    } st_t;

    wr_t wr_q[$];
    st_t st_q[$];

    int n_checks   = 0;
    int n_fail     = 0;
    int req_pulses = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [AW-1:0] a, input logic [7:0] d, input logic last,
                        input logic expect_wr);
        ld_valid = 1'b1;
        ld_addr  = a;
        ld_data  = d;
        ld_last  = last;
        if (expect_wr) wr_q.push_back({a, d});
        tick();
    endtask

    // Memory-write monitor: every observed write must match the oldest expected one.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && mem_wr_en === 1'b1) begin
                n_checks++;
                if (wr_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL mem_write: unexpected write addr 0x%0h data 0x%0h, none expected",
                             mem_addr, mem_dat);
                end else begin
                    e = wr_q.pop_front();
                    if (mem_addr !== e.addr || mem_dat !== e.dat) begin
                        n_fail++;
                        $display("FAIL mem_write: got addr 0x%0h data 0x%0h expected addr 0x%0h data 0x%0h",
                                 mem_addr, mem_dat, e.addr, e.dat);
                    end
                end
            end
        end
    end

    // Completion monitor: on a rising done/timeout flag, compare the full status against the oldest expectation.
    initial begin
        st_t  e;
        st_t  act;
        logic prev_flag;
        prev_flag = 1'b0;
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && (done | timeout) === 1'b1 && !prev_flag) begin
                n_checks++;
                act = {done, timeout, cycle_count, core_reset};
                if (st_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL run_status: unexpected completion done=%0b timeout=%0b count=%0d",
                             done, timeout, cycle_count);
                end else begin
                    e = st_q.pop_front();
                    if (act !== e) begin
                        n_fail++;
                        $display("FAIL run_status: got done=%0b timeout=%0b count=%0d core_reset=%0b expected done=%0b timeout=%0b count=%0d core_reset=%0b",
                                 act.done, act.timeout, act.cnt, act.core_reset,
                                 e.done, e.timeout, e.cnt, e.core_reset);
                    end
                end
            end
            prev_flag = ((done | timeout) === 1'b1);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && core_req === 1'b1) req_pulses++;
        end
    end

    initial begin
        // ---- reset values ----
        repeat (2) @(posedge clk);
        #1;
        check("rst_core_reset", 32'(core_reset), 1);
        check("rst_mem_wr_en",  32'(mem_wr_en), 0);
        check("rst_ld_ready",   32'(ld_ready), 0);
        check("rst_core_req",   32'(core_req), 0);
        check("rst_busy",       32'(busy), 0);
        check("rst_done",       32'(done), 0);
        check("rst_timeout",    32'(timeout), 0);
        check("rst_cycle_count", 32'(cycle_count), 0);
        check("rst_load_csum",  32'(load_csum), 0);
        reset = 1'b1;
        tick();

        // ---- reset mid-LOAD after three bytes ----
        start = 1'b1;
        tick();
        start = 1'b0;
        check("load_ld_ready", 32'(ld_ready), 1);
        check("load_busy",     32'(busy), 1);
        send(8'h20, 8'hA1, 1'b0, 1'b1);
        send(8'h21, 8'hB2, 1'b0, 1'b1);
        send(8'h22, 8'hC3, 1'b0, 1'b0);   // this write is aborted by reset
        check("pre_abort_wr_en", 32'(mem_wr_en), 1);
        reset = 1'b0;
        #1;
        check("abort_mem_wr_en",  32'(mem_wr_en), 0);
        check("abort_mem_addr",   32'(mem_addr), 0);
        check("abort_ld_ready",   32'(ld_ready), 0);
        check("abort_busy",       32'(busy), 0);
        check("abort_core_reset", 32'(core_reset), 1);
        check("abort_load_csum",  32'(load_csum), 0);
        ld_valid = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        // Bytes offered in IDLE must be ignored.
        ld_valid = 1'b1;
        ld_addr  = 8'h30;
        ld_data  = 8'h55;
        repeat (3) tick();
        check("idle_ld_ready", 32'(ld_ready), 0);
        check("idle_busy",     32'(busy), 0);
        ld_valid = 1'b0;
        tick();

        // ---- three-byte load, core_done on 10th RUN cycle ----
        start = 1'b1;
        tick();
        start = 1'b0;
        send(8'h00, 8'h12, 1'b0, 1'b1);
        send(8'h01, 8'h34, 1'b0, 1'b1);
        send(8'h02, 8'h56, 1'b1, 1'b1);
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        check("crst1_core_reset", 32'(core_reset), 1);
        check("crst1_busy",       32'(busy), 1);
        check("crst1_ld_ready",   32'(ld_ready), 0);
        check("crst1_mem_wr_en",  32'(mem_wr_en), 1);
        check("crst1_mem_addr",   32'(mem_addr), 32'h02);
        tick();
        check("crst2_core_reset", 32'(core_reset), 1);
        check("crst2_core_req",   32'(core_req), 0);
        check("crst2_mem_wr_en",  32'(mem_wr_en), 0);
        tick();
        check("run1_core_req",    32'(core_req), 1);
        check("run1_cycle_count", 32'(cycle_count), 1);
        check("run1_core_reset",  32'(core_reset), 0);
        check("run1_load_csum",   32'(load_csum), 32'(8'h70 & CS_MASK));
        tick();
        check("run2_core_req",    32'(core_req), 0);
        check("run2_cycle_count", 32'(cycle_count), 2);
        start = 1'b1;                      // ignored in RUN
        tick();
        start = 1'b0;
        check("run_start_busy",   32'(busy), 1);
        check("run_start_count",  32'(cycle_count), 3);
        check("run_start_ready",  32'(ld_ready), 0);
        repeat (7) tick();
        check("run10_cycle_count", 32'(cycle_count), 10);
        core_done = 1'b1;
        st_q.push_back({1'b1, 1'b0, 16'd10, 1'b0});
        tick();
        core_done = 1'b0;
        check("done_busy", 32'(busy), 0);
        check("done_flag", 32'(done), 1);
        core_done = 1'b1;                  // ignored in DONE
        tick();
        core_done = 1'b0;
        tick();
        check("done_hold_flag",  32'(done), 1);
        check("done_hold_count", 32'(cycle_count), 10);
        check("done_core_reset", 32'(core_reset), 0);

        // ---- restart from DONE, timeout at 20 cycles ----
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_done",     32'(done), 0);
        check("restart_timeout",  32'(timeout), 0);
        check("restart_count",    32'(cycle_count), 0);
        check("restart_csum",     32'(load_csum), 0);
        check("restart_ld_ready", 32'(ld_ready), 1);
        send(8'h10, 8'hAB, 1'b1, 1'b1);
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        tick();
        tick();
        check("t_run1_count", 32'(cycle_count), 1);
        repeat (19) tick();
        check("t_run20_count", 32'(cycle_count), 20);
        st_q.push_back({1'b0, 1'b1, 16'd20, 1'b1});
        tick();
        check("tout_flag",       32'(timeout), 1);
        check("tout_done",       32'(done), 0);
        check("tout_core_reset", 32'(core_reset), 1);
        check("tout_busy",       32'(busy), 0);
        check("tout_count",      32'(cycle_count), 20);
        check("tout_csum",       32'(load_csum), 32'(8'hAB & CS_MASK));
        tick();
        check("tout_hold", 32'(timeout), 1);

        // ---- restart from TOUT, core_done coinciding with the limit ----
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart2_timeout", 32'(timeout), 0);
        send(8'h11, 8'h0F, 1'b1, 1'b1);
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        tick();
        tick();
        repeat (19) tick();
        check("tie_count", 32'(cycle_count), 20);
        core_done = 1'b1;
        st_q.push_back({1'b1, 1'b0, 16'd20, 1'b0});
        tick();
        core_done = 1'b0;
        check("tie_done",    32'(done), 1);
        check("tie_timeout", 32'(timeout), 0);

        // ---- drain and final accounting ----
        for (int i = 0; i < 50 && (wr_q.size() != 0 || st_q.size() != 0); i++) tick();
        check("wr_q_drained", 32'(wr_q.size()), 0);
        check("st_q_drained", 32'(st_q.size()), 0);
        check("core_req_pulses", 32'(req_pulses), 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
